// File: rtl/jtdd_gfx_rom_pkg.sv
// Shared encodings for the graphics ROM responder: client slot indices and
// fetch FSM states, plus the slot rotation helper used by the arbiter.
package jtdd_gfx_rom_pkg;

    typedef enum logic [1:0] {
        SLOT_CHAR = 2'd0,
        SLOT_SCR  = 2'd1,
        SLOT_OBJ  = 2'd2
    } slot_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int NSLOT = 3;

    function automatic slot_e slot_next(input slot_e s);
        case (s)
            SLOT_CHAR: return SLOT_SCR;
            SLOT_SCR:  return SLOT_OBJ;
            default:   return SLOT_CHAR;
        endcase
    endfunction

endpackage

// File: rtl/jtdd_rom_cache1.sv
// One-word tag/data/valid holder for a single ROM client; ok is combinational
// against the address the client is presenting right now.
module jtdd_rom_cache1 #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [AW-1:0] i_wtag,
    input  logic [15:0]   i_wdata,
    output logic [15:0]   o_data,
    output logic          o_ok
);
    logic          r_valid;
    logic [AW-1:0] r_tag;
    logic [15:0]   r_data;

    // Clear wins over a same-cycle write so fills during a download are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            if (i_we) begin
                r_tag   <= i_wtag;
                r_data  <= i_wdata;
                r_valid <= 1'b1;
            end
            if (i_clr) r_valid <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_ok   = r_valid & (r_tag == i_addr) & ~i_clr;

endmodule

// File: rtl/jtdd_gfx_rom.sv
// Graphics ROM responder: three one-word client caches sharing one SDRAM read
// port through a rotating-priority arbiter and a REQ/ack/data_rdy FSM.
module jtdd_gfx_rom
    import jtdd_gfx_rom_pkg::*;
#(
    parameter logic [21:0] CHAR_OFFSET = 22'h00000,
    parameter logic [21:0] SCR_OFFSET  = 22'h10000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [14:0] char_addr,
    output logic [7:0]  char_data,
    output logic        char_ok,
    input  logic [16:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        scr_ok,
    input  logic [17:0] obj_addr,
    output logic [15:0] obj_data,
    output logic        obj_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [15:0] sdram_dout
);
    state_e      r_state, w_state_nx;
    slot_e       r_slot, r_last, w_pick, w_cand;
    logic [17:0] r_tag;
    logic [21:0] r_sdram_addr;
    logic [21:0] w_word, w_off;
    logic [2:0]  w_ok, w_miss;
    logic        w_any, w_fill;
    logic [15:0] w_char_word;

    jtdd_rom_cache1 #(.AW(14)) u_char (
        .clk(clk), .rst(rst), .i_clr(downloading), .i_addr(char_addr[14:1]),
        .i_we(w_fill && r_slot == SLOT_CHAR), .i_wtag(r_tag[13:0]), .i_wdata(sdram_dout),
        .o_data(w_char_word), .o_ok(w_ok[SLOT_CHAR])
    );
    jtdd_rom_cache1 #(.AW(17)) u_scr (
        .clk(clk), .rst(rst), .i_clr(downloading), .i_addr(scr_addr),
        .i_we(w_fill && r_slot == SLOT_SCR), .i_wtag(r_tag[16:0]), .i_wdata(sdram_dout),
        .o_data(scr_data), .o_ok(w_ok[SLOT_SCR])
    );
    jtdd_rom_cache1 #(.AW(18)) u_obj (
        .clk(clk), .rst(rst), .i_clr(downloading), .i_addr(obj_addr),
        .i_we(w_fill && r_slot == SLOT_OBJ), .i_wtag(r_tag), .i_wdata(sdram_dout),
        .o_data(obj_data), .o_ok(w_ok[SLOT_OBJ])
    );

    assign char_data = char_addr[0] ? w_char_word[15:8] : w_char_word[7:0];
    assign char_ok   = w_ok[SLOT_CHAR];
    assign scr_ok    = w_ok[SLOT_SCR];
    assign obj_ok    = w_ok[SLOT_OBJ];
    assign w_miss    = ~w_ok & {3{~downloading}};

    // Search starts at the slot after the one served last.
    always_comb begin
        w_any  = 1'b0;
        w_cand = slot_next(r_last);
        w_pick = w_cand;
        for (int i = 0; i < NSLOT; i++) begin
            if (!w_any && w_miss[w_cand]) begin
                w_pick = w_cand;
                w_any  = 1'b1;
            end
            w_cand = slot_next(w_cand);
        end
    end

    always_comb begin
        case (w_pick)
            SLOT_CHAR: begin w_word = {8'd0, char_addr[14:1]}; w_off = CHAR_OFFSET; end
            SLOT_SCR:  begin w_word = {5'd0, scr_addr};        w_off = SCR_OFFSET;  end
            default:   begin w_word = {4'd0, obj_addr};        w_off = OBJ_OFFSET;  end
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_fill     = 1'b0;
        case (r_state)
            IDLE: if (w_any) w_state_nx = REQ;
            REQ: begin
                if (sdram_ack) begin
                    w_fill     = data_rdy;
                    w_state_nx = data_rdy ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (data_rdy) begin
                    w_fill     = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_slot       <= SLOT_CHAR;
            r_last       <= SLOT_OBJ;
            r_tag        <= '0;
            r_sdram_addr <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == IDLE && w_any) begin
                r_slot       <= w_pick;
                r_last       <= w_pick;
                r_tag        <= w_word[17:0];
                r_sdram_addr <= w_off + w_word;
            end
        end
    end

    assign sdram_req  = (r_state == REQ);
    assign sdram_addr = r_sdram_addr;

endmodule

// File: tb/tb_jtdd_gfx_rom.sv
// Self-checking bench: cycle-level behavioural model of the three client caches
// and the arbiter, with a randomized SDRAM responder and directed scenarios.
module tb_jtdd_gfx_rom;
    localparam logic [21:0] C_OFF = 22'h00000;
    localparam logic [21:0] S_OFF = 22'h10000;
    localparam logic [21:0] O_OFF = 22'h3D0000;

    logic        clk = 1'b0;
    logic        rst, downloading;
    logic [14:0] char_addr;
    logic [16:0] scr_addr;
    logic [17:0] obj_addr;
    logic [7:0]  char_data;
    logic [15:0] scr_data, obj_data, sdram_dout;
    logic        char_ok, scr_ok, obj_ok, sdram_req, sdram_ack, data_rdy;
    logic [21:0] sdram_addr;

    jtdd_gfx_rom #(.CHAR_OFFSET(C_OFF), .SCR_OFFSET(S_OFF), .OBJ_OFFSET(O_OFF)) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
        .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .sdram_dout(sdram_dout)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    // model: phase 0 idle, 1 request outstanding, 2 waiting for data
    int          m_ph = 0, m_slot = 0, m_last = 2;
    logic [21:0] m_sa = '0;
    logic [17:0] m_tagw = '0;
    bit          m_valid [3];
    logic [17:0] m_tag [3];
    logic [15:0] m_data [3];
    int          p_ack = 100, p_rdy = 100, p_both = 0, p_spur = 0;
    bit          ovr_en = 0;
    logic [21:0] ovr_addr = '0;
    logic [15:0] ovr_val = '0;
    logic [21:0] req_log [$];
    bit          prev_req = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] word_of(input int k);
        if (k == 0) return {4'd0, char_addr[14:1]};
        if (k == 1) return {1'b0, scr_addr};
        return obj_addr;
    endfunction

    function automatic logic [21:0] off_of(input int k);
        return (k == 0) ? C_OFF : (k == 1) ? S_OFF : O_OFF;
    endfunction

    function automatic bit ok_of(input int k);
        return m_valid[k] && m_tag[k] == word_of(k) && !downloading;
    endfunction

    function automatic logic [15:0] mem(input logic [21:0] a);
        logic [31:0] h;
        h = {10'd0, a} * 32'd40503 ^ {16'd0, a[21:6]};
        return h[15:0];
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    function automatic bit all_ok();
        return ok_of(0) && ok_of(1) && ok_of(2) && m_ph == 0;
    endfunction

    task automatic step();
        logic [7:0] cb;
        bit fill, found;
        int k;
        @(negedge clk);
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        if (m_ph == 1) begin
            sdram_ack = pct(p_ack);
            data_rdy  = sdram_ack && pct(p_both);
        end else if (m_ph == 2) data_rdy = pct(p_rdy);
        else data_rdy = pct(p_spur);
        if (m_ph == 0) sdram_dout = 16'($urandom);
        else sdram_dout = (ovr_en && m_sa == ovr_addr) ? ovr_val : mem(m_sa);
        #1;
        chk("sdram_req", {31'd0, sdram_req}, {31'd0, m_ph == 1});
        if (m_ph == 1) chk("sdram_addr", {10'd0, sdram_addr}, {10'd0, m_sa});
        chk("char_ok", {31'd0, char_ok}, {31'd0, ok_of(0)});
        chk("scr_ok", {31'd0, scr_ok}, {31'd0, ok_of(1)});
        chk("obj_ok", {31'd0, obj_ok}, {31'd0, ok_of(2)});
        cb = char_addr[0] ? m_data[0][15:8] : m_data[0][7:0];
        if (ok_of(0)) chk("char_data", {24'd0, char_data}, {24'd0, cb});
        if (ok_of(1)) chk("scr_data", {16'd0, scr_data}, {16'd0, m_data[1]});
        if (ok_of(2)) chk("obj_data", {16'd0, obj_data}, {16'd0, m_data[2]});
        if (sdram_req && !prev_req) req_log.push_back(sdram_addr);
        prev_req = sdram_req;
        if (rst) begin
            m_ph = 0; m_last = 2;
            for (int i = 0; i < 3; i++) m_valid[i] = 0;
        end else begin
            fill = 0; found = 0;
            case (m_ph)
                0: for (int i = 0; i < 3; i++) begin
                    k = (m_last + 1 + i) % 3;
                    if (!found && !ok_of(k) && !downloading) begin
                        found = 1; m_slot = k; m_last = k; m_ph = 1;
                        m_tagw = word_of(k);
                        m_sa = 22'(off_of(k) + {4'd0, word_of(k)});
                    end
                end
                1: if (sdram_ack) begin fill = data_rdy; m_ph = data_rdy ? 0 : 2; end
                default: if (data_rdy) begin fill = 1; m_ph = 0; end
            endcase
            if (fill && !downloading) begin
                m_valid[m_slot] = 1; m_tag[m_slot] = m_tagw; m_data[m_slot] = sdram_dout;
            end
            if (downloading) for (int i = 0; i < 3; i++) m_valid[i] = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_ok(input string tag, input int max);
        int n = 0;
        while (!all_ok() && n < max) begin step(); n++; end
        total++;
        assert (all_ok()) else begin
            bad++;
            $error("FAIL %s timeout observed=%0d cycles expected=fill", tag, n);
        end
    endtask

    task automatic wait_wait(input string tag, input int max);
        int n = 0;
        while (m_ph != 2 && n < max) begin step(); n++; end
        total++;
        assert (m_ph == 2) else begin
            bad++;
            $error("FAIL %s timeout observed=%0d expected=2", tag, m_ph);
        end
    endtask

    initial begin
        int n0;
        rst = 1; downloading = 0; sdram_ack = 0; data_rdy = 0; sdram_dout = '0;
        char_addr = '0; scr_addr = '0; obj_addr = '0;
        for (int i = 0; i < 3; i++) begin m_valid[i] = 0; m_tag[i] = '0; m_data[i] = '0; end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_req", {31'd0, sdram_req}, 32'd0);
        chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
        chk("rst_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);

        // first fetches: char wins, then scr, then obj (which wraps)
        char_addr = 15'h0003; scr_addr = 17'h00010; obj_addr = 18'h3FFFF;
        ovr_en = 1; ovr_addr = 22'h000001; ovr_val = 16'hABCD;
        run_until_ok("fill3", 60);
        chk("order0", {10'd0, req_log[0]}, 32'h000001);
        chk("order1", {10'd0, req_log[1]}, 32'h010010);
        chk("order2_wrap", {10'd0, req_log[2]}, 32'h00FFFF);
        chk("char_hi", {24'd0, char_data}, 32'hAB);
        char_addr = 15'h0002;
        #1;
        chk("char_lo_ok", {31'd0, char_ok}, 32'd1);
        chk("char_lo", {24'd0, char_data}, 32'hCD);
        ovr_en = 0;

        // scr and obj miss together: rotation continues, scr first
        scr_addr = 17'h00011; obj_addr = 18'h00005;
        run_until_ok("fill2", 40);
        chk("order3", {10'd0, req_log[3]}, 32'h010011);
        chk("order4", {10'd0, req_log[4]}, 32'h3D0005);

        // address change while waiting for data
        p_rdy = 0; scr_addr = 17'h00010;
        wait_wait("wait_scr", 20);
        scr_addr = 17'h00020;
        step(); step();
        p_rdy = 100;
        step();
        chk("stale_fill_ok", {31'd0, scr_ok}, 32'd0);
        n0 = req_log.size();
        run_until_ok("refetch", 40);
        chk("refetch_n", req_log.size(), n0 + 1);
        chk("refetch_addr", {10'd0, req_log[$]}, 32'h010020);

        // ack and data_rdy together
        p_both = 100; char_addr = 15'h0100;
        step(); step();
        chk("coinc_ok", {31'd0, char_ok}, 32'd1);
        chk("coinc_req", {31'd0, sdram_req}, 32'd0);
        p_both = 0;

        // reset in WAIT, then a stray data_rdy
        p_rdy = 0; char_addr = 15'h0200;
        wait_wait("wait_rst", 20);
        rst = 1; step(); rst = 0;
        chk("mid_rst_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
        chk("mid_rst_req", {31'd0, sdram_req}, 32'd0);
        chk("mid_rst_addr", {10'd0, sdram_addr}, 32'd0);
        p_spur = 100; p_rdy = 100; p_ack = 0;
        step();
        p_spur = 0;
        chk("spur_ok", {31'd0, char_ok}, 32'd0);
        chk("fresh_req", {31'd0, sdram_req}, 32'd1);
        chk("fresh_addr", {10'd0, sdram_addr}, 32'h000100);
        p_ack = 100;
        run_until_ok("post_rst", 60);

        // download: outstanding fetch completes but is dropped, no new requests
        p_rdy = 0; obj_addr = 18'h00100;
        wait_wait("wait_dl", 20);
        downloading = 1;
        p_rdy = 100;
        repeat (4) step();
        chk("dl_req", {31'd0, sdram_req}, 32'd0);
        chk("dl_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
        downloading = 0;
        run_until_ok("post_dl", 60);

        // random traffic
        for (int t = 0; t < 600; t++) begin
            if (pct(15)) char_addr = 15'($urandom_range(0, 7)) | (pct(10) ? 15'h7FF8 : 15'h0);
            if (pct(15)) scr_addr = 17'($urandom_range(0, 5)) | (pct(10) ? 17'h1FFF0 : 17'h0);
            if (pct(15)) obj_addr = 18'($urandom_range(0, 5)) | (pct(20) ? 18'h3FFF0 : 18'h0);
            if (pct(3)) downloading = ~downloading;
            p_ack = $urandom_range(30, 100); p_rdy = $urandom_range(30, 100);
            p_both = $urandom_range(0, 50); p_spur = $urandom_range(0, 20);
            step();
        end
        downloading = 0; p_ack = 100; p_rdy = 100; p_spur = 0;
        run_until_ok("final", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
